// File: rtl/rf_loader_pkg.sv
// rtl/rf_loader_pkg.sv - shared widths and FSM state type for the register-file loader
package rf_loader_pkg;

  localparam int RF_ADDR_WIDTH = 2;
  localparam int RF_DATA_WIDTH = 32;
  localparam int NUM_REGS      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_FLUSH,
    ST_DONE
  } rf_loader_state_t;

endpackage

// File: rtl/rf_loader.sv
// rtl/rf_loader.sv - command/payload sequencer issuing registered writes into the config register file
module rf_loader
  import rf_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = rf_loader_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_clear,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [ADDR_WIDTH-1:0] cmd_cnt,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wren,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

  rf_loader_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d;
  logic                  rf_wren_q, rf_wren_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    rf_wren_d = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (cmd_clear) begin
            ptr_d   = '0;
            state_d = ST_CLEAR;
          end else begin
            ptr_d   = cmd_base;
            len_d   = cmd_cnt;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (din_valid) begin
          rf_addr_d = ptr_q;
          rf_data_d = din_data;
          rf_wren_d = 1'b1;
          ptr_d     = ptr_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == len_q) state_d = ST_FLUSH;
        end
      end
      ST_CLEAR: begin
        rf_addr_d = ptr_q;
        rf_data_d = '0;
        rf_wren_d = 1'b1;
        ptr_d     = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LAST_REG) state_d = ST_FLUSH;
      end
      // Last write is on the port this cycle; done follows once it has landed.
      ST_FLUSH: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      rf_wren_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      rf_wren_q <= rf_wren_d;
      done_q    <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign din_ready = (state_q == ST_LOAD);
  assign rf_addr   = rf_addr_q;
  assign rf_wren   = rf_wren_q;
  assign rf_data   = rf_data_q;
  assign done      = done_q;

endmodule
